// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: result-source encoding, load funct3 codes
// and the MEM/WB pipeline register layout.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } resultsrc_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    resultsrc_t        resultsrc;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   read_data;
    logic [XLEN-1:0]   pc4;
  } memwb_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a loaded word and sign/zero-extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[7:0];
    case (off)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase

    // Halfword alignment ignores off[0]; misaligned halves are not trapped here.
    half_sel = off[1] ? raw[31:16] : raw[15:0];

    load_data_c = raw;
    case (funct3)
      F3_LB:   load_data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data_c = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   load_data_c = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_data_c = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data_c = raw;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, result select, register-file write gating
// and retired-instruction counter.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stall_w,
  input  logic                  i_flush_w,
  input  logic                  i_valid_m,
  input  logic                  i_regwrite_m,
  input  logic [1:0]            i_resultsrc_m,
  input  logic [2:0]            i_funct3_m,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_m,
  input  logic [DATA_WIDTH-1:0] i_alu_result_m,
  input  logic [DATA_WIDTH-1:0] i_read_data_m,
  input  logic [DATA_WIDTH-1:0] i_pc4_m,
  output logic                  o_reg_write_w,
  output logic [ADDR_WIDTH-1:0] o_rd_addr_w,
  output logic [DATA_WIDTH-1:0] o_result_w,
  output logic                  o_retire_w,
  output logic                  o_illegal_w,
  output logic [CNT_WIDTH-1:0]  o_instret
);

  memwb_t                wb_q;
  logic [CNT_WIDTH-1:0]  instret_q;
  logic [DATA_WIDTH-1:0] load_data_c;
  logic [DATA_WIDTH-1:0] result_c;
  logic                  rsvd_c;
  logic                  retire_c;

  // MEM/WB register; a flush drops the whole payload to a clean bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_q <= '0;
    end else if (i_flush_w) begin
      wb_q <= '0;
    end else if (!i_stall_w) begin
      wb_q.valid      <= i_valid_m;
      wb_q.regwrite   <= i_regwrite_m;
      wb_q.resultsrc  <= resultsrc_t'(i_resultsrc_m);
      wb_q.funct3     <= i_funct3_m;
      wb_q.rd         <= i_rd_addr_m;
      wb_q.alu_result <= i_alu_result_m;
      wb_q.read_data  <= i_read_data_m;
      wb_q.pc4        <= i_pc4_m;
    end
  end

  load_extend u_load_extend (
    .raw         (wb_q.read_data),
    .off         (wb_q.alu_result[1:0]),
    .funct3      (wb_q.funct3),
    .load_data_c (load_data_c)
  );

  always_comb begin
    result_c = '0;
    case (wb_q.resultsrc)
      RES_ALU: result_c = wb_q.alu_result;
      RES_MEM: result_c = load_data_c;
      RES_PC4: result_c = wb_q.pc4;
      default: result_c = '0;
    endcase
  end

  assign rsvd_c   = (wb_q.resultsrc == RES_RSVD);
  // Retire on the cycle the instruction leaves W; reset discards it uncounted.
  assign retire_c = wb_q.valid & ~i_stall_w & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instret_q <= '0;
    end else if (retire_c) begin
      instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  assign o_reg_write_w = wb_q.valid & wb_q.regwrite & (wb_q.rd != '0) & ~rsvd_c & ~i_rst;
  assign o_rd_addr_w   = wb_q.rd;
  assign o_result_w    = result_c;
  assign o_retire_w    = retire_c;
  assign o_illegal_w   = wb_q.valid & rsvd_c;
  assign o_instret     = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed traffic, a per-cycle reference model and
// hand-computed checkpoints. Counter is shrunk to 4 bits to exercise wrap.
module tb_writeback_stage;
  import riscv_pkg::*;

  localparam int unsigned CW = 4;

  logic          i_clk;
  logic          i_rst;
  logic          i_stall_w;
  logic          i_flush_w;
  logic          i_valid_m;
  logic          i_regwrite_m;
  logic [1:0]    i_resultsrc_m;
  logic [2:0]    i_funct3_m;
  logic [4:0]    i_rd_addr_m;
  logic [31:0]   i_alu_result_m;
  logic [31:0]   i_read_data_m;
  logic [31:0]   i_pc4_m;
  logic          o_reg_write_w;
  logic [4:0]    o_rd_addr_w;
  logic [31:0]   o_result_w;
  logic          o_retire_w;
  logic          o_illegal_w;
  logic [CW-1:0] o_instret;

  int n_vec = 0;
  int n_err = 0;

  writeback_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(CW)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_stall_w      (i_stall_w),
    .i_flush_w      (i_flush_w),
    .i_valid_m      (i_valid_m),
    .i_regwrite_m   (i_regwrite_m),
    .i_resultsrc_m  (i_resultsrc_m),
    .i_funct3_m     (i_funct3_m),
    .i_rd_addr_m    (i_rd_addr_m),
    .i_alu_result_m (i_alu_result_m),
    .i_read_data_m  (i_read_data_m),
    .i_pc4_m        (i_pc4_m),
    .o_reg_write_w  (o_reg_write_w),
    .o_rd_addr_w    (o_rd_addr_w),
    .o_result_w     (o_result_w),
    .o_retire_w     (o_retire_w),
    .o_illegal_w    (o_illegal_w),
    .o_instret      (o_instret)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the instruction sitting in W plus a retire count.
  bit          m_init  = 0;
  bit          m_known = 0;
  bit          m_v, m_rw;
  logic [1:0]  m_rs;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_rdat, m_pc4;
  int unsigned m_cnt;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] raw,
                                           input logic [31:0] addr);
    logic [7:0]  b;
    logic [15:0] h;
    int unsigned ofs;
    ofs = int'(addr) & 3;
    b = 8'(raw >> (8 * ofs));
    h = 16'(raw >> (16 * (ofs / 2)));
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b100:  return {24'h0, b};
      3'b001:  return 32'($signed(h));
      3'b101:  return {16'h0, h};
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] ref_result();
    case (m_rs)
      2'd0:    return m_alu;
      2'd1:    return ref_load(m_f3, m_rdat, m_alu);
      2'd2:    return m_pc4;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge i_clk) begin
    if (i_rst) begin
      m_init = 1; m_known = 1;
      m_v = 0; m_rw = 0; m_rs = 0; m_f3 = 0; m_rd = 0;
      m_alu = 0; m_rdat = 0; m_pc4 = 0; m_cnt = 0;
    end else if (m_init) begin
      if (m_v && !i_stall_w) m_cnt = (m_cnt + 1) % (1 << CW);
      if (i_flush_w) begin
        m_v = 0; m_rw = 0; m_known = 0;
      end else if (!i_stall_w) begin
        m_v = i_valid_m; m_rw = i_regwrite_m; m_rs = i_resultsrc_m; m_f3 = i_funct3_m;
        m_rd = i_rd_addr_m; m_alu = i_alu_result_m; m_rdat = i_read_data_m;
        m_pc4 = i_pc4_m; m_known = 1;
      end
    end
  end

  always @(negedge i_clk) begin
    if (m_init) begin
      chk("reg_write", 64'(o_reg_write_w),
          64'(m_v && m_rw && m_rd != 0 && m_rs != 2'd3 && !i_rst));
      chk("retire", 64'(o_retire_w), 64'(m_v && !i_stall_w && !i_rst));
      chk("illegal", 64'(o_illegal_w), 64'(m_v && m_rs == 2'd3));
      chk("instret", 64'(o_instret), 64'(m_cnt));
      if (m_known) begin
        chk("rd_addr", 64'(o_rd_addr_w), 64'(m_rd));
        chk("result", 64'(o_result_w), 64'(ref_result()));
      end
    end
  end

  task automatic drive(input logic v, input logic rw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rdat, input logic [31:0] pc4);
    i_valid_m = v; i_regwrite_m = rw; i_resultsrc_m = rs; i_funct3_m = f3;
    i_rd_addr_m = rd; i_alu_result_m = alu; i_read_data_m = rdat; i_pc4_m = pc4;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_clk = 0; i_rst = 1; i_stall_w = 0; i_flush_w = 0;
    i_valid_m = 1; i_regwrite_m = 1; i_resultsrc_m = 2'd0; i_funct3_m = F3_LW;
    i_rd_addr_m = 5'd5; i_alu_result_m = 32'h55; i_read_data_m = 32'h0; i_pc4_m = 32'h0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("lit_rst_instret", 64'(o_instret), 64'd0);
    chk("lit_rst_wr", 64'(o_reg_write_w), 64'd0);
    chk("lit_rst_result", 64'(o_result_w), 64'd0);
    chk("lit_rst_rd", 64'(o_rd_addr_w), 64'd0);
    chk("lit_rst_retire", 64'(o_retire_w), 64'd0);
    chk("lit_rst_illegal", 64'(o_illegal_w), 64'd0);
    i_rst = 0;

    drive(1, 1, RES_MEM, F3_LB, 5'd3, 32'h1003, 32'h8899AABB, 32'h0);
    chk("lit_lb", 64'(o_result_w), 64'hFFFFFF88);
    chk("lit_lb_wr", 64'(o_reg_write_w), 64'd1);
    drive(1, 1, RES_MEM, F3_LBU, 5'd3, 32'h1003, 32'h8899AABB, 32'h0);
    chk("lit_lbu", 64'(o_result_w), 64'h00000088);
    drive(1, 1, RES_MEM, F3_LH, 5'd3, 32'h1002, 32'h8899AABB, 32'h0);
    chk("lit_lh", 64'(o_result_w), 64'hFFFF8899);
    drive(1, 1, RES_MEM, F3_LHU, 5'd3, 32'h1000, 32'h8899AABB, 32'h0);
    chk("lit_lhu", 64'(o_result_w), 64'h0000AABB);
    drive(1, 1, RES_MEM, F3_LW, 5'd3, 32'h1003, 32'h8899AABB, 32'h0);
    chk("lit_lw", 64'(o_result_w), 64'h8899AABB);

    drive(1, 1, RES_ALU, F3_LW, 5'd0, 32'h5, 32'h0, 32'h0);
    chk("lit_x0_wr", 64'(o_reg_write_w), 64'd0);
    chk("lit_x0_retire", 64'(o_retire_w), 64'd1);
    drive(1, 1, RES_RSVD, F3_LW, 5'd7, 32'h1234, 32'h0, 32'h0);
    chk("lit_rsvd_illegal", 64'(o_illegal_w), 64'd1);
    chk("lit_rsvd_result", 64'(o_result_w), 64'd0);
    chk("lit_rsvd_wr", 64'(o_reg_write_w), 64'd0);

    drive(1, 1, RES_ALU, F3_LW, 5'd9, 32'hABC, 32'h0, 32'h0);
    chk("lit_pre_stall_cnt", 64'(o_instret), 64'd7);
    i_stall_w = 1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, RES_ALU, F3_LW, 5'd10, 32'hDEF, 32'h0, 32'h0);
      chk("lit_stall_wr", 64'(o_reg_write_w), 64'd1);
      chk("lit_stall_result", 64'(o_result_w), 64'hABC);
      chk("lit_stall_cnt", 64'(o_instret), 64'd7);
    end
    i_stall_w = 0;
    #1;
    chk("lit_unstall_retire", 64'(o_retire_w), 64'd1);
    @(posedge i_clk);
    #1;
    chk("lit_unstall_cnt", 64'(o_instret), 64'd8);
    chk("lit_unstall_result", 64'(o_result_w), 64'hDEF);

    i_flush_w = 1;
    drive(1, 1, RES_ALU, F3_LW, 5'd11, 32'h111, 32'h0, 32'h0);
    i_flush_w = 0;
    chk("lit_flush_wr", 64'(o_reg_write_w), 64'd0);
    chk("lit_flush_retire", 64'(o_retire_w), 64'd0);
    chk("lit_flush_cnt", 64'(o_instret), 64'd9);

    drive(1, 1, RES_ALU, F3_LW, 5'd12, 32'h222, 32'h0, 32'h0);
    i_flush_w = 1; i_stall_w = 1;
    drive(1, 1, RES_ALU, F3_LW, 5'd13, 32'h333, 32'h0, 32'h0);
    i_flush_w = 0; i_stall_w = 0;
    chk("lit_flush_stall_cnt", 64'(o_instret), 64'd9);
    chk("lit_flush_stall_wr", 64'(o_reg_write_w), 64'd0);

    drive(1, 1, RES_PC4, F3_LW, 5'd1, 32'h0, 32'h0, 32'h104);
    chk("lit_pc4", 64'(o_result_w), 64'h104);
    chk("lit_pc4_wr", 64'(o_reg_write_w), 64'd1);

    i_rst = 1;
    #1;
    chk("lit_midrst_wr", 64'(o_reg_write_w), 64'd0);
    chk("lit_midrst_retire", 64'(o_retire_w), 64'd0);
    @(posedge i_clk);
    #1;
    chk("lit_midrst_cnt", 64'(o_instret), 64'd0);
    i_rst = 0;

    for (int i = 0; i < 17; i++)
      drive(1, 1, RES_ALU, F3_LW, 5'(i % 31 + 1), 32'(i), 32'h0, 32'h0);
    drive(0, 0, RES_ALU, F3_LW, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("lit_wrap_cnt", 64'(o_instret), 64'd1);
    repeat (3) @(posedge i_clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the pipelined RISC-V core: holds the MEM/WB pipeline register, selects the writeback result and sign/zero-extends load data. It drives the register-file write port consumed by the decode stage (`*_w` write enable, destination address, result), mirrors those signals to the hazard/forwarding unit, and counts retired instructions.

## Interface
- `DATA_WIDTH`, 32, datapath width
- `ADDR_WIDTH`, 5, register address width
- `CNT_WIDTH`, 64, retired-instruction counter width

- `i_clk`  in  1  clock; one clock domain
- `i_rst`  in  1  reset; synchronous, active-high
- `i_stall_w`  in  1  hold MEM/WB register contents
- `i_flush_w`  in  1  load a bubble into MEM/WB
- `i_valid_m`  in  1  MEM stage holds a real instruction
- `i_regwrite_m`  in  1  instruction writes rd
- `i_resultsrc_m`  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved
- `i_funct3_m`  in  3  load size/sign field
- `i_rd_addr_m`  in  ADDR_WIDTH  destination register
- `i_alu_result_m`  in  DATA_WIDTH  ALU result / load address
- `i_read_data_m`  in  DATA_WIDTH  raw word from data memory
- `i_pc4_m`  in  DATA_WIDTH  PC+4 of instruction
- `o_reg_write_w`  out  1  register-file write enable to decode
- `o_rd_addr_w`  out  ADDR_WIDTH  write address to decode
- `o_result_w`  out  DATA_WIDTH  write data to decode / forwarding
- `o_retire_w`  out  1  one-cycle pulse per retired instruction
- `o_illegal_w`  out  1  W holds a valid instruction with resultsrc 11
- `o_instret`  out  CNT_WIDTH  retired-instruction count

## Operation
- **MEM/WB register:** fields are valid, regwrite, resultsrc, funct3, rd, alu_result, read_data, pc4.
- **Update priority:** `i_rst` > `i_flush_w` > `i_stall_w` > load.
  - Flush clears valid and regwrite; other fields are don't-care.
  - Stall holds all fields.
- **Result mux (combinational from the register):**
  - 00: alu_result.
  - 01: extended load.
  - 10: pc4.
  - 11: result 0, write suppressed, `o_illegal_w` = 1.
- **Load extension.** `off` = alu_result[1:0].
  - funct3 000 lb: byte at `off`, sign-extended.
  - 100 lbu: byte at `off`, zero-extended.
  - 001 lh: half selected by `off[1]`, sign-extended; `off[0]` ignored.
  - 101 lhu: same half selection, zero-extended.
  - 010 lw, and any other funct3: full word.
- **Write enable:** `o_reg_write_w` = valid & regwrite & (rd ≠ 0) & (resultsrc ≠ 11) & ~`i_rst`. `o_rd_addr_w` always passes the registered rd.
- **Retire:** `o_retire_w` = valid & ~`i_stall_w` & ~`i_rst`. A stalled instruction therefore retires exactly once, on the cycle it leaves W. Illegal instructions still retire.
- **Counter:** `o_instret` increments on each edge where `o_retire_w` = 1 and wraps modulo 2^CNT_WIDTH.

## Timing
- **Latency:** one cycle. MEM inputs sampled at edge N appear on all `*_w` outputs after edge N. The register file commits at edge N+1.
- **Outputs:** all combinational from registered state; no input-to-output combinational path except `i_stall_w`/`i_rst` gating of `o_retire_w`, and `i_rst` gating of `o_reg_write_w`.
- **Reset values** (after the reset edge): valid 0, all fields 0, `o_reg_write_w` 0, `o_rd_addr_w` 0, `o_result_w` 0, `o_retire_w` 0, `o_illegal_w` 0, `o_instret` 0.
- **Reset mid-operation:** during any cycle with `i_rst` high, write and retire are suppressed. The instruction in W is discarded and not counted.
- **Simultaneous flush and stall:** flush wins. The departing instruction retires if `i_stall_w` is low; if stalled, it is squashed without retiring.
- **Counter wrap:** all-ones + 1 → 0 on the same edge, with no flag.

## Structure
- **Shared package `riscv_pkg`:**
  - `resultsrc_t` enum: `RES_ALU`, `RES_MEM`, `RES_PC4`, `RES_RSVD`.
  - Load funct3 constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - A `memwb_t` struct for the pipeline register.
- **Sub-module `load_extend`:** purely combinational; inputs raw word, offset, funct3; output extended value.
- **Top:** the register, result mux, write gating and counter stay in `writeback_stage`.

## Test plan
- **Reset:** hold `i_rst` for 2 cycles while the inputs carry valid write traffic → all outputs 0 and `o_instret` = 0.
- **Loads:** read_data=0x8899AABB, alu_result=0x1003.
  - lb → 0xFFFFFF88.
  - lbu → 0x00000088.
  - lh (addr 0x1002) → 0xFFFF8899.
  - lhu (addr 0x1000) → 0x0000AABB.
  - lw → 0x8899AABB.
- **x0 and reserved suppression:**
  - rd=0, regwrite=1, ALU 0x5 → `o_reg_write_w`=0, `o_retire_w`=1.
  - resultsrc=11 → `o_illegal_w`=1, `o_result_w`=0, no write.
- **Stall then flush:** stall an instruction for 3 cycles → write stays asserted, exactly one retire pulse. Flush with stall low → next cycle valid=0, no write; `o_instret` +1 for the departing instruction only.
- **PC+4 and wrap:** jal with pc4=0x104, rd=1 → `o_result_w`=0x104. With CNT_WIDTH=4, retire 17 instructions → `o_instret`=1.
